// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift/rotate unit with valid/ready handshake and flush.
// Define SHIFT_PERF_CNT_EN to build the completed-op and stall counters.
module shift_exec_stage #(
   parameter int unsigned SHAMT_WIDTH = 4,
   localparam int unsigned WIDTH = 2 ** SHAMT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] in_shamt,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [15:0]      perf_done,
   output logic [15:0]      perf_stall
);

   typedef enum logic [1:0] {
      OpRol = 2'b00,
      OpSll = 2'b01,
      OpRor = 2'b10,
      OpSrl = 2'b11
   } op_e;

   logic                   s1_valid_q;
   logic [WIDTH-1:0]       s1_data_q;
   op_e                    s1_op_q;
   logic [SHAMT_WIDTH-1:0] s1_amt_q;
   logic                   s1_zero_q;

   logic                   s2_valid_q;
   logic [WIDTH-1:0]       s2_data_q;

   logic                   s1_adv;
   logic                   s2_adv;
   logic                   in_xfer;
   logic                   out_xfer;
   logic                   in_oor;
   logic                   in_is_shift;
   logic [WIDTH-1:0]       result;
   logic [2*WIDTH-1:0]     dbl;
   logic [2*WIDTH-1:0]     rotl_w;
   logic [2*WIDTH-1:0]     rotr_w;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv && rst_n && !flush;
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = s2_valid_q && out_ready;

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;

   // Low amount bits are the rotate modulus and the in-range shift amount alike.
   assign in_oor      = |in_shamt[WIDTH-1:SHAMT_WIDTH];
   assign in_is_shift = in_op[0];

   always_comb begin
      dbl    = {s1_data_q, s1_data_q};
      rotl_w = dbl << s1_amt_q;
      rotr_w = dbl >> s1_amt_q;
      result = '0;
      unique case (s1_op_q)
         OpRol:   result = rotl_w[2*WIDTH-1:WIDTH];
         OpSll:   result = s1_data_q << s1_amt_q;
         OpRor:   result = rotr_w[WIDTH-1:0];
         OpSrl:   result = s1_data_q >> s1_amt_q;
         default: result = '0;
      endcase
      if (s1_zero_q) begin
         result = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_op_q    <= OpRol;
         s1_amt_q   <= '0;
         s1_zero_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         if (flush) begin
            s1_valid_q <= 1'b0;
         end else if (s1_adv) begin
            s1_valid_q <= in_valid;
         end
         if (in_xfer) begin
            s1_data_q <= in_data;
            s1_op_q   <= op_e'(in_op);
            s1_amt_q  <= in_shamt[SHAMT_WIDTH-1:0];
            s1_zero_q <= in_is_shift && in_oor;
         end

         if (flush) begin
            s2_valid_q <= 1'b0;
         end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
         end
         // Data only moves with a real op so out_data holds while idle.
         if (!flush && s2_adv && s1_valid_q) begin
            s2_data_q <= result;
         end
      end
   end

`ifdef SHIFT_PERF_CNT_EN
   logic [15:0] done_q;
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_q  <= '0;
         stall_q <= '0;
      end else begin
         if (out_xfer && (done_q != 16'hFFFF)) begin
            done_q <= done_q + 16'd1;
         end
         if (s2_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
      end
   end

   assign perf_done  = done_q;
   assign perf_stall = stall_q;
`else
   logic unused_xfer;
   assign unused_xfer = out_xfer;
   assign perf_done   = '0;
   assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage (16-bit build).
module tb_shift_exec_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [15:0] in_shamt;
   logic [1:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [15:0] perf_done;
   logic [15:0] perf_stall;

   int n_checks = 0;
   int n_errors = 0;

   shift_exec_stage #(.SHAMT_WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .perf_done (perf_done),
      .perf_stall(perf_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic [15:0] s,
                        input logic [1:0] op);
      in_valid = v;
      in_data  = d;
      in_shamt = s;
      in_op    = op;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      step();
      rst_n = 1'b1;
   endtask

   // Single op with out_ready high: result must appear exactly two edges after issue.
   task automatic run_op(input string tag, input logic [15:0] d, input logic [15:0] s,
                         input logic [1:0] op, input logic [15:0] exp);
      out_ready = 1'b1;
      drive(1'b1, d, s, op);
      #1;
      check({tag, "_in_ready"}, {15'b0, in_ready}, 16'h1);
      step();
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      check({tag, "_valid_lat1"}, {15'b0, out_valid}, 16'h0);
      step();
      check({tag, "_valid_lat2"}, {15'b0, out_valid}, 16'h1);
      check({tag, "_data"}, out_data, exp);
   endtask

   typedef struct {
      string       tag;
      logic [15:0] d;
      logic [15:0] s;
      logic [1:0]  op;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{"ror4",     16'h1234, 16'h0004, 2'b10, 16'h4123};
      vecs[1]  = '{"rol1",     16'h8001, 16'h0001, 2'b00, 16'h0003};
      vecs[2]  = '{"srl15",    16'h8000, 16'h000F, 2'b11, 16'h0001};
      vecs[3]  = '{"sll0",     16'h00F0, 16'h0000, 2'b01, 16'h00F0};
      vecs[4]  = '{"sll16",    16'hFFFF, 16'h0010, 2'b01, 16'h0000};
      vecs[5]  = '{"srlffff",  16'hFFFF, 16'hFFFF, 2'b11, 16'h0000};
      vecs[6]  = '{"ror20",    16'h1234, 16'h0014, 2'b10, 16'h4123};
      vecs[7]  = '{"rol4",     16'h1234, 16'h0004, 2'b00, 16'h2341};
      vecs[8]  = '{"sll4",     16'h1234, 16'h0004, 2'b01, 16'h2340};
      vecs[9]  = '{"srl4",     16'h1234, 16'h0004, 2'b11, 16'h0123};
      vecs[10] = '{"rol16",    16'h1234, 16'h0010, 2'b00, 16'h1234};
      vecs[11] = '{"sll15",    16'h0001, 16'h000F, 2'b01, 16'h8000};

      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      step();
      step();
      check("rst_in_ready_low", {15'b0, in_ready}, 16'h0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready_rel", {15'b0, in_ready}, 16'h1);
      check("rst_out_valid", {15'b0, out_valid}, 16'h0);
      check("rst_out_data", out_data, 16'h0000);
      check("rst_perf_done", perf_done, 16'h0);
      check("rst_perf_stall", perf_stall, 16'h0);

      foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].d, vecs[i].s, vecs[i].op, vecs[i].exp);
      step();

      // Backpressure: A, B fill s2/s1 while out_ready is low; C waits for out_ready.
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 16'h1234, 16'h0004, 2'b10);       // A -> 0x4123
      #1;
      check("bp_a_ready", {15'b0, in_ready}, 16'h1);
      step();
      drive(1'b1, 16'h8001, 16'h0001, 2'b00);       // B -> 0x0003
      check("bp_b_ready", {15'b0, in_ready}, 16'h1);
      step();
      drive(1'b1, 16'h00F0, 16'h0004, 2'b01);       // C -> 0x0F00
      for (int k = 0; k < 3; k++) begin
         check("bp_full_ready", {15'b0, in_ready}, 16'h0);
         check("bp_hold_valid", {15'b0, out_valid}, 16'h1);
         check("bp_hold_data", out_data, 16'h4123);
         step();
      end
      check("bp_hold_data_last", out_data, 16'h4123);
      out_ready = 1'b1;
      #1;
      check("bp_c_ready", {15'b0, in_ready}, 16'h1);
      step();
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      check("bp_b_out", out_data, 16'h0003);
      check("bp_b_valid", {15'b0, out_valid}, 16'h1);
      step();
      check("bp_c_out", out_data, 16'h0F00);
      check("bp_c_valid", {15'b0, out_valid}, 16'h1);
      step();
      check("bp_drained", {15'b0, out_valid}, 16'h0);
      check("bp_idle_data", out_data, 16'h0F00);

      run_op("p4", 16'h0F00, 16'h0008, 2'b10, 16'h000F);
      run_op("p5", 16'h00FF, 16'h0004, 2'b11, 16'h000F);
      step();
`ifdef SHIFT_PERF_CNT_EN
      check("perf_done", perf_done, 16'd5);
      check("perf_stall", perf_stall, 16'd3);
`else
      check("perf_done_off", perf_done, 16'd0);
      check("perf_stall_off", perf_stall, 16'd0);
`endif

      // Flush with two ops in flight and a simultaneous request.
      out_ready = 1'b1;
      drive(1'b1, 16'h1111, 16'h0001, 2'b01);
      step();
      drive(1'b1, 16'h2222, 16'h0001, 2'b01);
      step();
      flush = 1'b1;
      drive(1'b1, 16'h3333, 16'h0001, 2'b01);
      #1;
      check("fl_in_ready", {15'b0, in_ready}, 16'h0);
      check("fl_presented", {15'b0, out_valid}, 16'h1);
      step();
      flush = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      check("fl_valid_next", {15'b0, out_valid}, 16'h0);
      step();
      check("fl_valid_2", {15'b0, out_valid}, 16'h0);
      step();
      check("fl_not_accepted", {15'b0, out_valid}, 16'h0);
      run_op("fl_new", 16'h1234, 16'h0008, 2'b00, 16'h3412);
      step();

      // Reset mid-stream discards in-flight ops and clears counters.
      out_ready = 1'b0;
      drive(1'b1, 16'hAAAA, 16'h0001, 2'b11);
      step();
      drive(1'b1, 16'h5555, 16'h0001, 2'b11);
      step();
      drive(1'b0, 16'h0, 16'h0, 2'b00);
      rst_n = 1'b0;
      #1;
      check("mr_in_ready_low", {15'b0, in_ready}, 16'h0);
      step();
      check("mr_out_valid", {15'b0, out_valid}, 16'h0);
      check("mr_perf_done", perf_done, 16'h0);
      check("mr_perf_stall", perf_stall, 16'h0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      check("mr_no_out_1", {15'b0, out_valid}, 16'h0);
      step();
      check("mr_no_out_2", {15'b0, out_valid}, 16'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
